// File: rtl/dmi_access_pkg.sv
// Shared encodings and types for the DMI access controller: op/status codes,
// FSM state encoding and the {addr, data, op} word layout.
package dmi_access_pkg;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_FAILED = 2'd2;
  localparam logic [1:0] ST_BUSY   = 2'd3;

  localparam logic [1:0] STATE_IDLE      = 2'd0;
  localparam logic [1:0] STATE_REQ       = 2'd1;
  localparam logic [1:0] STATE_WAIT_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE      = STATE_IDLE,
    S_REQ       = STATE_REQ,
    S_WAIT_RESP = STATE_WAIT_RESP
  } dmi_state_e;

  // Address field sized for the widest supported ABITS; narrower builds zero-extend.
  localparam int unsigned DMI_ADDR_MAX = 32;

  typedef struct packed {
    logic [DMI_ADDR_MAX-1:0] addr;
    logic [31:0]             data;
    logic [1:0]              op;
  } dmi_word_t;

  function automatic logic op_is_access(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/dmi_access_ctrl.sv
// DMI access controller: turns DTM update strobes into one debug-module transaction
// and keeps the sticky busy/failed status. Optional response timeout: DMI_ACCESS_TIMEOUT_EN.
module dmi_access_ctrl
  import dmi_access_pkg::*;
#(
  parameter int unsigned ABITS          = 7,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             update_i,
  input  logic             capture_i,
  input  logic [ABITS+33:0] dmi_wdata_i,
  output logic [ABITS+33:0] dmi_rdata_o,
  input  logic             dmireset_i,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output logic [ABITS-1:0] dmi_req_addr_o,
  output logic [31:0]      dmi_req_data_o,
  output logic [1:0]       dmi_req_op_o,
  input  logic             dmi_resp_valid_i,
  output logic             dmi_resp_ready_o,
  input  logic [31:0]      dmi_resp_data_i,
  input  logic             dmi_resp_err_i,
  output logic             busy_o
);

  // Request channel: valid/ready, a beat transfers on a clock edge where both are 1;
  // addr/data/op stay stable while valid is high. Response channel uses the same rule.

  dmi_state_e       state_q, state_d;
  dmi_word_t        req_q, req_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       err_q, err_d;
  logic [ABITS+33:0] cap_q, cap_d;
  dmi_word_t        upd_word;
  logic [1:0]       status;
  logic             addr_unused;

`ifdef DMI_ACCESS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES < 2);
`endif

  always_comb begin
    upd_word      = '0;
    upd_word.addr = DMI_ADDR_MAX'(dmi_wdata_i[ABITS+33:34]);
    upd_word.data = dmi_wdata_i[33:2];
    upd_word.op   = dmi_wdata_i[1:0];
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef DMI_ACCESS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (update_i && op_is_access(upd_word.op) && (err_q == ST_OK)) begin
          req_d   = upd_word;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
`ifdef DMI_ACCESS_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (dmi_req_ready_i) state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (dmi_resp_valid_i) begin
          if (req_q.op == OP_READ) rdata_d = dmi_resp_data_i;
          if (dmi_resp_err_i && (err_q == ST_OK)) err_d = ST_FAILED;
          state_d = S_IDLE;
        end
`ifdef DMI_ACCESS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          if (err_q == ST_OK) err_d = ST_FAILED;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // First error sticks; any DTM access during a transaction reports busy.
    if ((update_i || capture_i) && (state_q != S_IDLE) && (err_q == ST_OK)) err_d = ST_BUSY;
    if (dmireset_i) err_d = ST_OK;
  end

  always_comb begin
    if (err_q != ST_OK)         status = err_q;
    else if (state_q != S_IDLE) status = ST_BUSY;
    else                        status = ST_OK;
    cap_d = {req_q.addr[ABITS-1:0], rdata_q, status};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= ST_OK;
      cap_q   <= '0;
`ifdef DMI_ACCESS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cap_q   <= cap_d;
`ifdef DMI_ACCESS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign addr_unused      = |(req_q.addr >> ABITS);
  assign dmi_req_valid_o  = (state_q == S_REQ);
  assign dmi_req_addr_o   = req_q.addr[ABITS-1:0];
  assign dmi_req_data_o   = req_q.data;
  assign dmi_req_op_o     = req_q.op;
  assign dmi_resp_ready_o = (state_q == S_WAIT_RESP);
  assign dmi_rdata_o      = cap_q;
  assign busy_o           = (state_q != S_IDLE);

endmodule

// File: doc/dmi_access_ctrl.md
# dmi_access_ctrl

Single-clock DMI access controller between the already clock-synchronised JTAG DTM shift/update logic and the RISC-V debug module's DMI port. Converts DTM `update` strobes carrying a 41-bit `dmi` word into one request/response transaction on the debug module. It also maintains the sticky busy/error status the DTM reports on the next `capture`. It is the stage that feeds the debug module exercised by the PMS JTAG debug tests.

## Interface
Parameters:
- `ABITS`, 7: DMI address width.
- `TIMEOUT_CYCLES`, 1024: response timeout, used only when the timeout feature is compiled in. Minimum 2.

Ports:
- `clk_i`  in  1  system clock
- `rst_i`  in  1  reset; synchronous, active-high
- `update_i`  in  1  one-cycle strobe: DTM `dmi` register updated
- `capture_i`  in  1  one-cycle strobe: DTM about to capture `dmi`
- `dmi_wdata_i`  in  ABITS+34  shifted word {addr, data[31:0], op[1:0]}
- `dmi_rdata_o`  out  ABITS+34  capture word {last addr, last rdata, status[1:0]}
- `dmireset_i`  in  1  one-cycle strobe: clear sticky error
- `dmi_req_valid_o`  out  1  request to debug module
- `dmi_req_ready_i`  in  1
- `dmi_req_addr_o`  out  ABITS
- `dmi_req_data_o`  out  32
- `dmi_req_op_o`  out  2  1 = read, 2 = write
- `dmi_resp_valid_i`  in  1
- `dmi_resp_ready_o`  out  1
- `dmi_resp_data_i`  in  32
- `dmi_resp_err_i`  in  1  response status failed
- `busy_o`  out  1  transaction in flight

## Operation
- FSM states: IDLE, REQ, WAIT_RESP.
- IDLE: on `update_i` with op = 1 or 2 and sticky error = 0, latch addr, data and op, then go to REQ. op = 0 is a nop. Op 3 is ignored.
- REQ: hold `dmi_req_valid_o` = 1 with stable addr, data and op until `dmi_req_ready_i`, then go to WAIT_RESP.
- WAIT_RESP: `dmi_resp_ready_o` = 1. On `dmi_resp_valid_i`:
  - Read: latch `dmi_resp_data_i` into rdata.
  - Write: rdata is unchanged.
  - If `dmi_resp_err_i`, sticky error = 2 (failed).
  - Go to IDLE.
- `update_i` outside IDLE: sticky error = 3 (busy). The request is dropped and the in-flight transaction completes normally.
- `capture_i` outside IDLE: sticky error = 3. The captured status reads 3.
- Status field priority: sticky error if nonzero, else 3 if not IDLE, else 0.
- Sticky error is non-zero ⇒ all updates are ignored. Only `dmireset_i` or reset clears it.
- `dmireset_i` in the same cycle as an error-setting event: the clear wins.
- `busy_o` = (state != IDLE).

## Timing
- Reset values:
  - State IDLE.
  - All `dmi_req_*_o` outputs = 0.
  - `dmi_resp_ready_o` = 0.
  - `dmi_rdata_o` = 0; sticky error = 0.
  - `busy_o` = 0.
- Reset asserted mid-transaction returns to IDLE next edge and drops the request. A response arriving afterwards is not accepted (ready = 0).
- `update_i` at edge n ⇒ `dmi_req_valid_o` = 1 at edge n+1.
- Request handshake at edge m ⇒ `dmi_resp_ready_o` = 1 from edge m+1.
- Response handshake at edge k ⇒ IDLE, with `dmi_rdata_o` updated at edge k+1.
- Minimum read round trip: 3 cycles update-to-IDLE with a zero-wait debug module.
- `dmi_rdata_o` is registered; its status bits reflect state as of the previous cycle.
- `update_i` coincident with the response handshake counts as busy (state not yet IDLE).

## Configuration
- `DMI_ACCESS_TIMEOUT_EN` defined:
  - A counter runs in WAIT_RESP.
  - On reaching `TIMEOUT_CYCLES` without a response: sticky error = 2, FSM returns to IDLE, `dmi_resp_ready_o` drops.
  - The counter clears on entry to WAIT_RESP.
- Not defined: no counter. WAIT_RESP waits indefinitely and `TIMEOUT_CYCLES` is unused.

## Structure
- The shared `dmi_access_pkg` holds:
  - op encodings (NOP = 0, READ = 1, WRITE = 2).
  - status encodings (OK = 0, FAILED = 2, BUSY = 3).
  - the FSM state enum.
  - a packed struct for the {addr, data, op} word.
- No sub-module. The optional timeout counter is inline logic.

## Test plan
- Read: update {addr 0x11, op 1}; the debug module answers 0x0000_0C82 after 2 wait cycles. Next capture → rdata 0x0000_0C82, status 0.
- Write: update {0x10, 0x8000_0001, op 2}. The request carries the exact addr and data. After the response, capture status = 0 and rdata is unchanged.
- Busy: a second update while in WAIT_RESP → status 3, and the second request is never issued. Later updates are ignored until `dmireset_i`; after it a new read succeeds.
- Error: `dmi_resp_err_i` = 1 → status 2, which persists across 3 captures until `dmireset_i`.
- Reset in REQ with `dmi_req_ready_i` = 0 → next cycle `dmi_req_valid_o` = 0, `busy_o` = 0, capture word = 0.
- With `DMI_ACCESS_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16 and no response → IDLE after exactly 16 WAIT_RESP cycles, status 2.
